// File: rtl/sap_display_scan.sv
// Four-digit multiplexed scanner for the SAP-1 front panel: snapshots machine state once per
// frame and emits one registered glyph code plus active-low digit enables per slot.
module sap_display_scan #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD       = 2,
    parameter int unsigned BLINK_DIV   = 125
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [1:0] mode,
    input  logic [7:0] out_reg,
    input  logic [3:0] pc,
    input  logic [7:0] acc,
    input  logic [2:0] tstate,
    input  logic       halt,
    output logic [4:0] sel,
    output logic [3:0] an_n
);

    localparam int unsigned PrescW = $clog2(REFRESH_DIV);
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PrescW-1:0] PLast  = PrescW'(REFRESH_DIV - 1);
    localparam logic [PrescW-1:0] PGuard = PrescW'(GUARD);
    localparam logic [PrescW-1:0] POne   = PrescW'(1);
    localparam logic [BlinkW-1:0] BLast  = BlinkW'(BLINK_DIV - 1);
    localparam logic [BlinkW-1:0] BOne   = BlinkW'(1);

    localparam logic [4:0] GlyphA     = 5'd10;
    localparam logic [4:0] GlyphBlank = 5'd16;
    localparam logic [4:0] GlyphDash  = 5'd17;
    localparam logic [4:0] GlyphP     = 5'd18;
    localparam logic [4:0] GlyphC     = 5'd19;
    localparam logic [4:0] GlyphT     = 5'd21;
    localparam logic [4:0] GlyphO     = 5'd22;

    logic [PrescW-1:0] p_q, p_d;
    logic [1:0]        d_q, d_d;
    logic [1:0]        snap_mode_q, snap_mode_d;
    logic [7:0]        snap_out_q, snap_out_d;
    logic [3:0]        snap_pc_q, snap_pc_d;
    logic [7:0]        snap_acc_q, snap_acc_d;
    logic [2:0]        snap_tstate_q, snap_tstate_d;
    logic              snap_halt_q, snap_halt_d;
    logic [BlinkW-1:0] b_q, b_d;
    logic              phase_q, phase_d;
    logic              tick, wrap;
    logic [4:0]        sel_d;
    logic [3:0]        an_d;

    always_comb begin
        tick = (p_q == PLast);
        wrap = tick && (d_q == 2'd0);
        p_d  = tick ? '0 : p_q + POne;
        d_d  = tick ? d_q - 2'd1 : d_q;

        snap_mode_d   = snap_mode_q;
        snap_out_d    = snap_out_q;
        snap_pc_d     = snap_pc_q;
        snap_acc_d    = snap_acc_q;
        snap_tstate_d = snap_tstate_q;
        snap_halt_d   = snap_halt_q;
        if (wrap) begin
            snap_mode_d   = mode;
            snap_out_d    = out_reg;
            snap_pc_d     = pc;
            snap_acc_d    = acc;
            snap_tstate_d = tstate;
            snap_halt_d   = halt;
        end

        // Blink state follows the snapshot being loaded so the new frame sees the new phase.
        b_d     = b_q;
        phase_d = phase_q;
        if (!snap_halt_d) begin
            b_d     = '0;
            phase_d = 1'b0;
        end else if (wrap) begin
            if (b_q == BLast) begin
                b_d     = '0;
                phase_d = ~phase_q;
            end else begin
                b_d = b_q + BOne;
            end
        end

        sel_d = GlyphBlank;
        unique case (snap_mode_d)
            2'd0: begin
                unique case (d_d)
                    2'd3: sel_d = GlyphO;
                    2'd2: sel_d = GlyphBlank;
                    2'd1: sel_d = {1'b0, snap_out_d[7:4]};
                    2'd0: sel_d = {1'b0, snap_out_d[3:0]};
                endcase
            end
            2'd1: begin
                unique case (d_d)
                    2'd3: sel_d = GlyphP;
                    2'd2: sel_d = GlyphC;
                    2'd1: sel_d = GlyphBlank;
                    2'd0: sel_d = {1'b0, snap_pc_d};
                endcase
            end
            2'd2: begin
                unique case (d_d)
                    2'd3: sel_d = GlyphA;
                    2'd2: sel_d = GlyphC;
                    2'd1: sel_d = {1'b0, snap_acc_d[7:4]};
                    2'd0: sel_d = {1'b0, snap_acc_d[3:0]};
                endcase
            end
            2'd3: begin
                unique case (d_d)
                    2'd3: sel_d = GlyphT;
                    2'd2: sel_d = GlyphDash;
                    2'd1: sel_d = GlyphBlank;
                    2'd0: begin
                        if (snap_tstate_d >= 3'd1 && snap_tstate_d <= 3'd6) begin
                            sel_d = {2'b00, snap_tstate_d};
                        end else begin
                            sel_d = GlyphDash;
                        end
                    end
                endcase
            end
        endcase
        if (snap_halt_d && phase_d) begin
            sel_d = GlyphBlank;
        end

        // sel only moves at slot start, which always falls inside the guard window.
        an_d = (p_d < PGuard) ? 4'b1111 : ~(4'b0001 << d_d);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            p_q           <= '0;
            d_q           <= 2'd3;
            snap_mode_q   <= 2'd0;
            snap_out_q    <= 8'd0;
            snap_pc_q     <= 4'd0;
            snap_acc_q    <= 8'd0;
            snap_tstate_q <= 3'd0;
            snap_halt_q   <= 1'b0;
            b_q           <= '0;
            phase_q       <= 1'b0;
            sel           <= GlyphBlank;
            an_n          <= 4'b1111;
        end else begin
            p_q           <= p_d;
            d_q           <= d_d;
            snap_mode_q   <= snap_mode_d;
            snap_out_q    <= snap_out_d;
            snap_pc_q     <= snap_pc_d;
            snap_acc_q    <= snap_acc_d;
            snap_tstate_q <= snap_tstate_d;
            snap_halt_q   <= snap_halt_d;
            b_q           <= b_d;
            phase_q       <= phase_d;
            sel           <= sel_d;
            an_n          <= an_d;
        end
    end

endmodule

// File: tb/tb_sap_display_scan.sv
// Bench for sap_display_scan: table of view vectors plus hand sequences, with a frame
// scoreboard fed by the driver and drained by a negedge monitor.
module tb_sap_display_scan;

    localparam int unsigned RD = 4;
    localparam int unsigned GD = 1;
    localparam int unsigned BD = 2;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] out_reg = 8'd0;
    logic [3:0] pc = 4'd0;
    logic [7:0] acc = 8'd0;
    logic [2:0] tstate = 3'd0;
    logic       halt = 1'b0;
    logic [4:0] sel;
    logic [3:0] an_n;

    int checks = 0;
    int errors = 0;

    sap_display_scan #(
        .REFRESH_DIV(RD),
        .GUARD      (GD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .mode   (mode),
        .out_reg(out_reg),
        .pc     (pc),
        .acc    (acc),
        .tstate (tstate),
        .halt   (halt),
        .sel    (sel),
        .an_n   (an_n)
    );

    always #5 clk = ~clk;

    // Digit 3 glyph sits in bits 19:15, digit 0 in bits 4:0.
    typedef logic [19:0] glyphs_t;
    typedef struct {
        int      frame;
        glyphs_t g;
    } sb_t;
    typedef struct {
        logic [1:0] mode;
        logic [7:0] out_reg;
        logic [3:0] pc;
        logic [7:0] acc;
        logic [2:0] tstate;
        glyphs_t    exp;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[8];

    function automatic glyphs_t gl(input int g3, input int g2, input int g1, input int g0);
        return {5'(g3), 5'(g2), 5'(g1), 5'(g0)};
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: assembles frames from slot starts and compares against the scoreboard.
    logic [3:0] prev_an = 4'hF;
    logic [4:0] prev_sel = 5'd16;
    int         frame_cnt = -1;
    logic       started = 1'b0;
    glyphs_t    cur = '0;

    always @(negedge clk) begin
        int dg;
        sb_t e;
        if (!clr_n) begin
            prev_an = 4'hF;
            started = 1'b0;
        end else begin
            if (an_n != 4'hF) begin
                chk("an_onehot", $countones(~an_n), 1);
                if (an_n == prev_an) begin
                    chk("sel_stable", int'(sel), int'(prev_sel));
                end else if (prev_an == 4'hF) begin
                    case (an_n)
                        4'b0111: dg = 3;
                        4'b1011: dg = 2;
                        4'b1101: dg = 1;
                        4'b1110: dg = 0;
                        default: dg = -1;
                    endcase
                    if (dg == 3) begin
                        frame_cnt++;
                        started = 1'b1;
                    end
                    if (dg >= 0) cur[dg*5 +: 5] = sel;
                    if (dg == 0 && started && sb.size() > 0) begin
                        if (sb[0].frame < frame_cnt) begin
                            chk("sb_missed_frame", frame_cnt, sb[0].frame);
                            void'(sb.pop_front());
                        end else if (sb[0].frame == frame_cnt) begin
                            e = sb.pop_front();
                            for (int k = 0; k < 4; k++) begin
                                chk($sformatf("frame%0d_digit%0d", frame_cnt, k),
                                    int'(cur[k*5 +: 5]), int'(e.g[k*5 +: 5]));
                            end
                        end
                    end
                end
            end
            prev_an  = an_n;
            prev_sel = sel;
        end
    end

    task automatic wait_frame_start();
        int f0 = frame_cnt;
        int n = 0;
        while (frame_cnt == f0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (frame_cnt == f0) chk("frame_timeout", 0, 1);
    endtask

    task automatic wait_an(input logic [3:0] v);
        int n = 0;
        while (an_n != v && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("wait_an", int'(an_n), int'(v));
    endtask

    task automatic push(input int frame, input glyphs_t g);
        sb_t e;
        e.frame = frame;
        e.g     = g;
        sb.push_back(e);
    endtask

    initial begin
        glyphs_t vis;
        glyphs_t blank;
        glyphs_t zero_view;
        int      m;
        int      slot;
        int      c;
        int      dg;
        logic [3:0] exp_an;

        vecs[0] = '{2'd0, 8'hA5, 4'h0, 8'h00, 3'd0, gl(22, 16, 10, 5)};
        vecs[1] = '{2'd2, 8'h00, 4'h0, 8'h3C, 3'd0, gl(10, 19, 3, 12)};
        vecs[2] = '{2'd1, 8'h00, 4'h9, 8'h00, 3'd0, gl(18, 19, 16, 9)};
        vecs[3] = '{2'd3, 8'h00, 4'h0, 8'h00, 3'd4, gl(21, 17, 16, 4)};
        vecs[4] = '{2'd3, 8'h00, 4'h0, 8'h00, 3'd0, gl(21, 17, 16, 17)};
        vecs[5] = '{2'd3, 8'h00, 4'h0, 8'h00, 3'd7, gl(21, 17, 16, 17)};
        vecs[6] = '{2'd3, 8'h00, 4'h0, 8'h00, 3'd6, gl(21, 17, 16, 6)};
        vecs[7] = '{2'd1, 8'hFF, 4'hF, 8'hFF, 3'd1, gl(18, 19, 16, 15)};
        vis       = gl(21, 17, 16, 4);
        blank     = gl(16, 16, 16, 16);
        zero_view = gl(22, 16, 0, 0);

        // Reset held for three clocks
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_sel", int'(sel), 16);
        chk("reset_an", int'(an_n), 15);
        clr_n = 1'b1;
        #1;
        chk("first_guard_an", int'(an_n), 15);

        // Cycle-exact first frame after reset: snapshot is all zero
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            slot   = i / 4;
            c      = i % 4;
            dg     = 3 - slot;
            exp_an = (c < int'(GD)) ? 4'hF : ~(4'b0001 << dg);
            chk($sformatf("scan_an_cyc%0d", i), int'(an_n), int'(exp_an));
            if (c >= 1) begin
                chk($sformatf("scan_sel_cyc%0d", i), int'(sel), int'(zero_view[dg*5 +: 5]));
            end
        end

        // View table
        for (int v = 0; v < 8; v++) begin
            wait_frame_start();
            mode    = vecs[v].mode;
            out_reg = vecs[v].out_reg;
            pc      = vecs[v].pc;
            acc     = vecs[v].acc;
            tstate  = vecs[v].tstate;
            push(frame_cnt + 1, vecs[v].exp);
        end

        // Snapshot isolation: change out_reg while digit 1 is lit
        wait_frame_start();
        mode    = 2'd0;
        out_reg = 8'h12;
        push(frame_cnt + 1, gl(22, 16, 1, 2));
        wait_frame_start();
        wait_an(4'b1101);
        out_reg = 8'h34;
        push(frame_cnt + 1, gl(22, 16, 3, 4));

        // Halt blink with BLINK_DIV=2
        wait_frame_start();
        m      = frame_cnt;
        mode   = 2'd3;
        tstate = 3'd4;
        halt   = 1'b1;
        push(m + 1, vis);
        push(m + 2, blank);
        push(m + 3, blank);
        push(m + 4, vis);
        push(m + 5, vis);
        push(m + 6, blank);
        repeat (6) wait_frame_start();
        halt = 1'b0;
        push(frame_cnt + 1, vis);
        wait_frame_start();
        halt = 1'b1;
        push(frame_cnt + 1, vis);
        push(frame_cnt + 2, blank);
        repeat (3) wait_frame_start();
        halt = 1'b0;
        chk("sb_drain", sb.size(), 0);

        // Asynchronous reset mid-slot at p=2, d=1
        mode = 2'd1;
        repeat (2) wait_frame_start();
        wait_an(4'b1101);
        @(negedge clk);
        #1;
        chk("pre_reset_an", int'(an_n), int'(4'b1101));
        clr_n = 1'b0;
        #1;
        chk("async_reset_an", int'(an_n), 15);
        chk("async_reset_sel", int'(sel), 16);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        #1;
        chk("rerun_guard_an", int'(an_n), 15);
        @(negedge clk);
        #1;
        chk("rerun_an_d3", int'(an_n), int'(4'b0111));
        chk("rerun_sel_zero_snap", int'(sel), 22);
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
